// File: rtl/yarp_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : yarp_fetch_unit
// Purpose  : Decoupled instruction fetch front end. Issues word-aligned fetch
//            requests over a req/gnt/rvalid memory interface with several
//            requests in flight, buffers {pc, instr} pairs in a small FIFO and
//            hands them to decode over a valid/ready handshake. A redirect
//            from execute flushes the FIFO and discards in-flight responses.
// Ports    : clk, reset (sync, active high)
//            redirect_i / redirect_pc_i         - redirect from execute
//            instr_mem_req_o / instr_mem_addr_o - fetch request and address
//            instr_mem_gnt_i                    - request accepted
//            instr_mem_rvalid_i / _rd_data_i    - in-order response
//            instr_valid_o / instr_o / instr_pc_o / instr_ready_i - to decode
//            fifo_count_o                       - buffer occupancy
// Options  : YARP_FETCH_PERF_EN adds perf_fetched_o / perf_discarded_o
//            (saturating 32-bit event counters).
// Revision : 1.0 - initial release
// ============================================================================
module yarp_fetch_unit #(
  parameter logic [31:0] RESET_PC        = 32'h1000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          redirect_i,
  input  logic [31:0]                   redirect_pc_i,
  output logic                          instr_mem_req_o,
  output logic [31:0]                   instr_mem_addr_o,
  input  logic                          instr_mem_gnt_i,
  input  logic                          instr_mem_rvalid_i,
  input  logic [31:0]                   instr_mem_rd_data_i,
  output logic                          instr_valid_o,
  output logic [31:0]                   instr_o,
  output logic [31:0]                   instr_pc_o,
  input  logic                          instr_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
`ifdef YARP_FETCH_PERF_EN
  ,
  output logic [31:0]                   perf_fetched_o,
  output logic [31:0]                   perf_discarded_o
`endif
);

  localparam int c_PTR_W = $clog2(FIFO_DEPTH);
  localparam int c_CNT_W = c_PTR_W + 1;
  localparam logic [c_CNT_W:0]   c_DEPTH   = (c_CNT_W + 1)'(FIFO_DEPTH);
  localparam logic [c_CNT_W-1:0] c_MAX_OUT = c_CNT_W'(MAX_OUTSTANDING);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [31:0]        r_fetch_pc;
  logic [31:0]        r_resp_pc;
  logic [63:0]        r_mem [FIFO_DEPTH];   // {pc, instr}
  logic [c_PTR_W-1:0] r_wr_ptr;
  logic [c_PTR_W-1:0] r_rd_ptr;
  logic [c_CNT_W-1:0] r_count;
  logic [c_CNT_W-1:0] r_outstanding;
  logic [c_CNT_W-1:0] r_discard;

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic [c_CNT_W:0]   w_credit;
  logic               w_req;
  logic               w_grant;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic [31:0]        w_redirect_pc;
  logic [63:0]        w_head;

  // Every granted request reserves a FIFO slot, so a response can always be
  // pushed without checking for a full FIFO.
  assign w_credit = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req    = !reset && !redirect_i && (w_credit < c_DEPTH)
                    && (r_outstanding < c_MAX_OUT);
  assign w_grant  = w_req && instr_mem_gnt_i;
  assign w_pop    = instr_valid_o && instr_ready_i;

  // A response in the redirect cycle belongs to the old stream and is always
  // dropped; otherwise it is dropped while stale responses are still pending.
  assign w_push   = instr_mem_rvalid_i && !redirect_i && (r_discard == '0);
  assign w_drop   = instr_mem_rvalid_i && (redirect_i || (r_discard != '0));

  assign w_redirect_pc = redirect_pc_i & 32'hFFFF_FFFC;
  assign w_head        = r_mem[r_rd_ptr];

  assign instr_mem_req_o  = w_req;
  assign instr_mem_addr_o = r_fetch_pc;
  assign instr_valid_o    = (r_count != '0);
  // Storage is not reset, so the head is masked while the FIFO is empty.
  assign instr_o          = instr_valid_o ? w_head[31:0]  : 32'h0;
  assign instr_pc_o       = instr_valid_o ? w_head[63:32] : 32'h0;
  assign fifo_count_o     = r_count;

  // --------------------------------------------------------------------------
  // FIFO storage (data only, no reset needed)
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {r_resp_pc, instr_mem_rd_data_i};
    end
  end

  // --------------------------------------------------------------------------
  // Pointers, counters and PCs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      // w_grant is low during a redirect, so this covers both cases.
      r_outstanding <= r_outstanding + c_CNT_W'(w_grant)
                       - c_CNT_W'(instr_mem_rvalid_i);
      if (redirect_i) begin
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        // Everything still in flight after this cycle is stale.
        r_discard  <= r_outstanding - c_CNT_W'(instr_mem_rvalid_i);
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + 32'd4;
        end
        if (instr_mem_rvalid_i && (r_discard != '0)) begin
          r_discard <= r_discard - c_CNT_W'(1);
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
          r_wr_ptr  <= r_wr_ptr + c_PTR_W'(1);
        end
        if (w_pop) begin
          r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
        end
        r_count <= r_count + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
      end
    end
  end

`ifdef YARP_FETCH_PERF_EN
  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [31:0]        r_perf_fetched;
  logic [31:0]        r_perf_discarded;
  logic [c_CNT_W-1:0] w_flush_cnt;
  logic [32:0]        w_fetched_sum;
  logic [32:0]        w_discarded_sum;

  // Entries thrown away by a redirect: whatever is buffered minus the one
  // decode takes in the same cycle.
  assign w_flush_cnt     = r_count - c_CNT_W'(w_pop);
  assign w_fetched_sum   = {1'b0, r_perf_fetched} + 33'(w_pop);
  assign w_discarded_sum = {1'b0, r_perf_discarded} + 33'(w_drop)
                           + (redirect_i ? 33'(w_flush_cnt) : 33'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched   <= '0;
      r_perf_discarded <= '0;
    end else begin
      r_perf_fetched   <= w_fetched_sum[32]   ? 32'hFFFF_FFFF : w_fetched_sum[31:0];
      r_perf_discarded <= w_discarded_sum[32] ? 32'hFFFF_FFFF : w_discarded_sum[31:0];
    end
  end

  assign perf_fetched_o   = r_perf_fetched;
  assign perf_discarded_o = r_perf_discarded;
`endif

  // A response with nothing in flight means the memory broke the protocol.
  a_no_orphan_rvalid : assert property (
    @(posedge clk) disable iff (reset) !(instr_mem_rvalid_i && (r_outstanding == '0))
  );

endmodule
`default_nettype wire

// File: tb/tb_yarp_fetch_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_yarp_fetch_unit
// Purpose  : Self-checking bench for yarp_fetch_unit. A transaction-level
//            model (queue of in-flight requests tagged stale/live, queue of
//            buffered {pc, instr}) predicts every output each cycle; directed
//            sequences pin latency, back-pressure, stalls, redirects and
//            address wrap with literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_yarp_fetch_unit;

  localparam logic [31:0] RESET_PC        = 32'h1000;
  localparam int          FIFO_DEPTH      = 4;
  localparam int          MAX_OUTSTANDING = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        instr_mem_req_o;
  logic [31:0] instr_mem_addr_o;
  logic        instr_mem_gnt_i = 1'b0;
  logic        instr_mem_rvalid_i = 1'b0;
  logic [31:0] instr_mem_rd_data_i = '0;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i = 1'b0;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_o;
`ifdef YARP_FETCH_PERF_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_discarded_o;
`endif

  always #5 clk = ~clk;

  yarp_fetch_unit #(
    .RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk(clk), .reset(reset),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .instr_mem_req_o(instr_mem_req_o), .instr_mem_addr_o(instr_mem_addr_o),
    .instr_mem_gnt_i(instr_mem_gnt_i), .instr_mem_rvalid_i(instr_mem_rvalid_i),
    .instr_mem_rd_data_i(instr_mem_rd_data_i),
    .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
    .instr_ready_i(instr_ready_i), .fifo_count_o(fifo_count_o)
`ifdef YARP_FETCH_PERF_EN
    , .perf_fetched_o(perf_fetched_o), .perf_discarded_o(perf_discarded_o)
`endif
  );

  // --------------------------------------------------------------------------
  // Reference model: requests in flight (in order) and buffered instructions
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          due;
  } flight_t;

  flight_t     inflight[$];
  logic [63:0] fifo_q[$];
  logic [31:0] m_fetch_pc = RESET_PC;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Stimulus knobs
  int          k_gnt_pct   = 100;
  int          k_ready_pct = 100;
  int          k_redir_pct = 0;
  int          k_lat_base  = 0;
  int          k_lat_jit   = 0;
  bit          f_redir     = 1'b0;
  logic [31:0] f_redir_pc  = '0;

  // Observations
  int          n_grants = 0;
  int          n_pops   = 0;
  int          first_gnt_cyc = -1;
  int          first_val_cyc = -1;
  logic [31:0] first_val_pc  = '0;
  logic        s_req;
  logic [31:0] s_addr;

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: drive at negedge, compare, advance the model, and return
  // 1 ns after the following posedge.
  task automatic step();
    bit      m_req;
    bit      m_pop;
    bit      rv;
    flight_t f;
    @(negedge clk);
    redirect_i    = f_redir || (!reset && ($urandom_range(99) < k_redir_pct));
    redirect_pc_i = f_redir ? f_redir_pc : $urandom;
    f_redir       = 1'b0;
    instr_mem_gnt_i = ($urandom_range(99) < k_gnt_pct);
    instr_ready_i   = ($urandom_range(99) < k_ready_pct);
    rv = !reset && (inflight.size() > 0) && (inflight[0].due <= cyc);
    instr_mem_rvalid_i  = rv;
    instr_mem_rd_data_i = rv ? mem_word(inflight[0].addr) : $urandom;
    #1;
    m_req = !reset && !redirect_i
            && (fifo_q.size() + inflight.size() < FIFO_DEPTH)
            && (inflight.size() < MAX_OUTSTANDING);
    chk("req", instr_mem_req_o, m_req);
    chk("addr", instr_mem_addr_o, m_fetch_pc);
    chk("valid", instr_valid_o, fifo_q.size() != 0);
    chk("count", fifo_count_o, fifo_q.size());
    if (fifo_q.size() != 0) begin
      chk("instr", instr_o, fifo_q[0][31:0]);
      chk("pc", instr_pc_o, fifo_q[0][63:32]);
    end
    s_req  = instr_mem_req_o;
    s_addr = instr_mem_addr_o;
    if (instr_mem_req_o && instr_mem_gnt_i) begin
      n_grants++;
      if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
    end
    if (instr_valid_o && instr_ready_i) n_pops++;
    if (instr_valid_o && first_val_cyc < 0) begin
      first_val_cyc = cyc;
      first_val_pc  = instr_pc_o;
    end

    m_pop = (fifo_q.size() != 0) && instr_ready_i;
    if (reset) begin
      inflight.delete();
      fifo_q.delete();
      m_fetch_pc = RESET_PC;
    end else begin
      if (m_pop) void'(fifo_q.pop_front());
      if (rv) begin
        f = inflight.pop_front();
        if (!f.stale && !redirect_i) fifo_q.push_back({f.addr, mem_word(f.addr)});
      end
      if (redirect_i) begin
        fifo_q.delete();
        foreach (inflight[i]) inflight[i].stale = 1'b1;
        m_fetch_pc = redirect_pc_i & 32'hFFFF_FFFC;
      end else if (m_req && instr_mem_gnt_i) begin
        f.addr  = m_fetch_pc;
        f.stale = 1'b0;
        f.due   = cyc + 1 + k_lat_base + $urandom_range(k_lat_jit);
        inflight.push_back(f);
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic clear_obs();
    n_grants = 0;
    n_pops = 0;
    first_gnt_cyc = -1;
    first_val_cyc = -1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    clear_obs();
  endtask

  task automatic wait_valid(string name);
    int w;
    w = 0;
    while (!instr_valid_o && w < 50) begin
      step();
      w++;
    end
    chk(name, instr_valid_o, 1'b1);
  endtask

  initial begin
    // ---- Reset state, latency and steady-state throughput ----
    step();
    step();
    chk("rst_req", s_req, 1'b0);
    chk("rst_addr", instr_mem_addr_o, RESET_PC);
    chk("rst_valid", instr_valid_o, 1'b0);
    chk("rst_count", fifo_count_o, 0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc", instr_pc_o, 32'h0);
    reset = 1'b0;
    clear_obs();
    repeat (6) step();
    chk("t1_latency", first_val_cyc - first_gnt_cyc, 2);
    chk("t1_first_pc", first_val_pc, 32'h1000);
    n_pops = 0;
    repeat (10) step();
    chk("t1_throughput", n_pops, 10);

    // ---- Back-pressure fills exactly FIFO_DEPTH entries ----
    do_reset();
    k_ready_pct = 0;
    repeat (12) step();
    chk("t2_grants", n_grants, 4);
    chk("t2_count", fifo_count_o, 4);
    chk("t2_req_low", s_req, 1'b0);
    n_grants = 0;
    k_ready_pct = 100;
    step();
    k_ready_pct = 0;
    repeat (8) step();
    chk("t2_one_more", n_grants, 1);
    chk("t2_count_again", fifo_count_o, 4);

    // ---- Grant stall holds the address ----
    do_reset();
    k_ready_pct = 100;
    step();
    step();
    k_gnt_pct = 0;
    repeat (3) begin
      step();
      chk("t3_req_held", s_req, 1'b1);
      chk("t3_addr_held", s_addr, 32'h1008);
    end
    k_gnt_pct = 100;
    step();
    chk("t3_addr_next", instr_mem_addr_o, 32'h100C);

    // ---- Redirect with responses in flight and entries buffered ----
    do_reset();
    k_ready_pct = 0;
    step();
    step();
    k_lat_base = 4;
    step();
    step();
    f_redir = 1'b1;
    f_redir_pc = 32'h2003;
    step();
    chk("t4_valid_flushed", instr_valid_o, 1'b0);
    chk("t4_count_flushed", fifo_count_o, 0);
    chk("t4_addr", instr_mem_addr_o, 32'h2000);
    k_lat_base = 0;
    wait_valid("t4_wait");
    chk("t4_first_pc", instr_pc_o, 32'h2000);
    chk("t4_first_instr", instr_o, mem_word(32'h2000));

    // ---- Redirect coinciding with a response, two outstanding ----
    do_reset();
    k_ready_pct = 100;
    k_lat_base = 1;
    step();
    step();
    f_redir = 1'b1;
    f_redir_pc = 32'h3000;
    step();
    k_lat_base = 0;
    wait_valid("t5_wait");
    chk("t5_first_pc", instr_pc_o, 32'h3000);

    // ---- Address wrap at 2^32 ----
    do_reset();
    f_redir = 1'b1;
    f_redir_pc = 32'hFFFF_FFFC;
    step();
    chk("t6_addr_top", instr_mem_addr_o, 32'hFFFF_FFFC);
    step();
    chk("t6_addr_wrap", instr_mem_addr_o, 32'h0000_0000);
    wait_valid("t6_wait");
    chk("t6_pc_top", instr_pc_o, 32'hFFFF_FFFC);
    step();
    chk("t6_pc_wrap", instr_pc_o, 32'h0000_0000);

    // ---- Randomized traffic against the model, with mid-run resets ----
    k_gnt_pct = 70; k_ready_pct = 60; k_redir_pct = 4;
    k_lat_base = 0; k_lat_jit = 3;
    for (int i = 0; i < 3000; i++) begin
      if (i % 700 == 699) do_reset();
      else step();
    end
    k_gnt_pct = 90; k_ready_pct = 20; k_redir_pct = 2; k_lat_jit = 5;
    repeat (1500) step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
